// File: rtl/dfc_sender.sv
// dfc_sender: transmit end of a delayed-flow-control link, 2-entry skid buffer feeding a
// registered valid/data pipeline. Define DFC_SENDER_DGATE_EN to zero p_data when p_vld is low.
module dfc_sender #(
    parameter int unsigned width      = 8,
    parameter int unsigned out_stages = 1,
    parameter int unsigned fc_stages  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    output logic             p_vld,
    output logic [width-1:0] p_data,
    input  logic             p_fc
);

    // Both pipelines need at least one flop.
    localparam int unsigned OS = (out_stages < 1) ? 1 : out_stages;
    localparam int unsigned FS = (fc_stages < 1) ? 1 : fc_stages;

    logic [width-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;
    logic             r_drdy;
    logic [FS-1:0]    r_fc;
    logic [OS-1:0]    r_vld;
    logic [width-1:0] r_data [OS];

    logic             w_push;
    logic             w_pop;
    logic             w_fc_q;
    logic [1:0]       w_occ_next;
    logic [width-1:0] w_stage0_data;

    assign w_fc_q = r_fc[FS-1];
    assign w_push = c_srdy & r_drdy;
    assign w_pop  = ~w_fc_q & (r_occ != 2'd0);

    always_comb begin
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + 2'd1;
            2'b01:   w_occ_next = r_occ - 2'd1;
            default: w_occ_next = r_occ;
        endcase
    end

    always_comb begin
`ifdef DFC_SENDER_DGATE_EN
        w_stage0_data = w_pop ? r_mem[r_rd_ptr] : '0;
`else
        w_stage0_data = w_pop ? r_mem[r_rd_ptr] : r_data[0];
`endif
    end

    // Skid buffer; c_drdy looks ahead at next occupancy so a push can never overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
            r_drdy   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= c_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ  <= w_occ_next;
            r_drdy <= (w_occ_next < 2'd2);
        end
    end

    // Flow-control pipeline resets to "stopped".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fc <= '1;
        end else begin
            r_fc[0] <= p_fc;
            for (int i = 1; i < int'(FS); i++) begin
                r_fc[i] <= r_fc[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            for (int i = 0; i < int'(OS); i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= w_pop;
            r_data[0] <= w_stage0_data;
            for (int i = 1; i < int'(OS); i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign c_drdy = r_drdy;
    assign p_vld  = r_vld[OS-1];
    assign p_data = r_data[OS-1];

endmodule

// File: tb/tb_dfc_sender.sv
// Scoreboard bench for dfc_sender: instance 0 uses default parameters, instance 1 uses
// out_stages=3, fc_stages=2 with p_fc toggling every cycle.
`timescale 1ns/1ps
module tb_dfc_sender;

    localparam int W   = 8;
    localparam int OS0 = 1;
    localparam int FS0 = 1;
    localparam int OS1 = 3;
    localparam int FS1 = 2;
    localparam int HN  = 8192;
`ifdef DFC_SENDER_DGATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst  [2];
    logic         srdy [2];
    logic [W-1:0] din  [2];
    logic         fc   [2];
    logic         drdy [2];
    logic         vld  [2];
    logic [W-1:0] dout [2];

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           acc_cnt [2] = '{0, 0};
    int           beats   [2] = '{0, 0};
    logic [W-1:0] exp_q [2][$];
    bit           fc_hist [2][HN];
    int           beat_cyc_q [$];
    bit           b_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dfc_sender #(.width(W), .out_stages(OS0), .fc_stages(FS0)) u_dut0 (
        .clk    (clk),
        .reset  (rst[0]),
        .c_srdy (srdy[0]),
        .c_drdy (drdy[0]),
        .c_data (din[0]),
        .p_vld  (vld[0]),
        .p_data (dout[0]),
        .p_fc   (fc[0])
    );

    dfc_sender #(.width(W), .out_stages(OS1), .fc_stages(FS1)) u_dut1 (
        .clk    (clk),
        .reset  (rst[1]),
        .c_srdy (srdy[1]),
        .c_drdy (drdy[1]),
        .c_data (din[1]),
        .p_vld  (vld[1]),
        .p_data (dout[1]),
        .p_fc   (fc[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A word on the link at cycle c was launched from a p_fc sample taken out+fc cycles earlier.
    function automatic int loop_depth(input int i);
        return (i == 0) ? OS0 + FS0 : OS1 + FS1;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int d;
            fc_hist[i][cyc % HN] = fc[i] | rst[i];
            if (rst[i]) begin
                exp_q[i].delete();
                chk("vld_in_reset", int'(vld[i]), 0);
            end else begin
                if (vld[i]) begin
                    beats[i]++;
                    if (i == 0) beat_cyc_q.push_back(cyc);
                    d = loop_depth(i);
                    chk("launch_while_fc_low", (cyc >= d) ? int'(fc_hist[i][(cyc - d) % HN]) : 1, 0);
                    if (exp_q[i].size() == 0) chk("spurious_word", int'(dout[i]), -1);
                    else chk("link_data", int'(dout[i]), int'(exp_q[i].pop_front()));
                end else if (GATED) begin
                    chk("gated_idle_data", int'(dout[i]), 0);
                end
                if (srdy[i] && drdy[i]) begin
                    exp_q[i].push_back(din[i]);
                    acc_cnt[i]++;
                end
            end
        end
    end

    task automatic step0(output bit acc, output int at);
        @(negedge clk);
        acc = srdy[0] && drdy[0];
        at  = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle0(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset0();
        rst[0]  = 1'b1;
        srdy[0] = 1'b0;
        idle0(2);
        rst[0] = 1'b0;
    endtask

    // Instance 1: random words, p_fc toggling every cycle.
    initial begin
        int sent;
        rst[1]  = 1'b1;
        srdy[1] = 1'b0;
        din[1]  = '0;
        fc[1]   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst[1] = 1'b0;
        sent = 0;
        for (int k = 0; k < 2000 && sent < 100; k++) begin
            fc[1]   = ~fc[1];
            srdy[1] = ($urandom_range(0, 3) != 0);
            din[1]  = W'($urandom);
            @(negedge clk);
            if (srdy[1] && drdy[1]) sent++;
            @(posedge clk);
            #1;
        end
        srdy[1] = 1'b0;
        repeat (40) begin
            fc[1] = ~fc[1];
            @(posedge clk);
            #1;
        end
        chk("b_accepted", sent, 100);
        chk("b_beats", beats[1], 100);
        chk("b_queue_empty", exp_q[1].size(), 0);
        b_done = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           acc;
        int           at;
        int           first_at;
        int           base_acc;
        int           base_beats;
        int           next;
        int           extra;
        int           rcyc;
        bit           raised;
        bit           lowered;
        logic [W-1:0] vals [3];

        rst[0] = 1'b1;
        srdy[0] = 1'b0;
        din[0] = '0;
        fc[0] = 1'b0;
        idle0(1);
        #1;
        chk("reset_drdy", int'(drdy[0]), 0);
        chk("reset_vld", int'(vld[0]), 0);
        chk("reset_data", int'(dout[0]), 0);
        reset0();
        @(posedge clk);
        #1;
        chk("drdy_after_release", int'(drdy[0]), 1);

        // Back-to-back 0x11, 0x22, 0x33.
        fc[0] = 1'b0;
        idle0(4);
        beat_cyc_q.delete();
        vals = '{8'h11, 8'h22, 8'h33};
        first_at = -1;
        for (int k = 0; k < 3; k++) begin
            srdy[0] = 1'b1;
            din[0]  = vals[k];
            acc     = 1'b0;
            for (int t = 0; t < 10 && !acc; t++) begin
                step0(acc, at);
                if (acc && first_at < 0) first_at = at;
            end
        end
        srdy[0] = 1'b0;
        idle0(6);
        chk("t1_beat_count", beat_cyc_q.size(), 3);
        if (beat_cyc_q.size() == 3) begin
            chk("t1_first_latency", beat_cyc_q[0] - first_at, OS0 + 1);
            chk("t1_back_to_back", beat_cyc_q[2] - beat_cyc_q[0], 2);
        end
        chk("t1_queue_empty", exp_q[0].size(), 0);

        // p_fc held high from reset: exactly two words taken, none launched.
        rst[0]  = 1'b1;
        fc[0]   = 1'b1;
        srdy[0] = 1'b1;
        next    = 8'h40;
        din[0]  = W'(next);
        idle0(2);
        rst[0]     = 1'b0;
        base_acc   = acc_cnt[0];
        base_beats = beats[0];
        for (int k = 0; k < 12; k++) begin
            step0(acc, at);
            if (acc) begin
                next++;
                din[0] = W'(next);
            end
        end
        chk("t2_accepted_while_stopped", acc_cnt[0] - base_acc, 2);
        chk("t2_no_launch", beats[0] - base_beats, 0);
        chk("t2_drdy_low", int'(drdy[0]), 0);
        fc[0] = 1'b0;
        for (int k = 0; k < 40 && acc_cnt[0] - base_acc < 8; k++) begin
            step0(acc, at);
            if (acc) begin
                next++;
                din[0] = W'(next);
            end
        end
        srdy[0] = 1'b0;
        idle0(8);
        chk("t2_beats", beats[0] - base_beats, 8);
        chk("t2_queue_empty", exp_q[0].size(), 0);

        // Stream 0x00..0x3F, stop when 0x10 reaches the link.
        reset0();
        fc[0] = 1'b0;
        idle0(4);
        base_beats = beats[0];
        next = 0; extra = 0; raised = 1'b0; lowered = 1'b0; rcyc = 0;
        for (int k = 0; k < 400 && next < 64; k++) begin
            bit raise_now;
            srdy[0] = 1'b1;
            din[0]  = W'(next);
            @(negedge clk);
            acc = srdy[0] && drdy[0];
            raise_now = !raised && vld[0] && (dout[0] == 8'h10);
            if (raised && !lowered && vld[0]) extra++;
            @(posedge clk);
            #1;
            if (acc) next++;
            if (raise_now) begin
                fc[0]  = 1'b1;
                raised = 1'b1;
                rcyc   = cyc;
            end else if (raised && !lowered && cyc - rcyc >= 10) begin
                chk("t3_extra_within_L", int'(extra <= OS0 + FS0 + 1), 1);
                fc[0]   = 1'b0;
                lowered = 1'b1;
            end
        end
        srdy[0] = 1'b0;
        idle0(12);
        chk("t3_fc_cycle_seen", int'(lowered), 1);
        chk("t3_all_sent", next, 64);
        chk("t3_beats", beats[0] - base_beats, 64);
        chk("t3_queue_empty", exp_q[0].size(), 0);

        // Reset with words buffered and one on the link.
        reset0();
        fc[0] = 1'b0;
        idle0(4);
        srdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din[0] = W'(8'hC0 + k);
            step0(acc, at);
        end
        fc[0] = 1'b1;
        din[0] = 8'hC8;
        @(negedge clk);
        @(negedge clk);
        chk("t5_inflight_before_reset", int'(vld[0]), 1);
        #2 rst[0] = 1'b1;
        srdy[0] = 1'b0;
        fc[0] = 1'b0;
        #1;
        chk("t5_async_vld", int'(vld[0]), 0);
        chk("t5_async_data", int'(dout[0]), 0);
        chk("t5_async_drdy", int'(drdy[0]), 0);
        @(posedge clk);
        idle0(2);
        rst[0] = 1'b0;
        base_beats = beats[0];
        idle0(10);
        chk("t5_no_stale_word", beats[0] - base_beats, 0);

        // Single 0xA5 then idle.
        srdy[0] = 1'b1;
        din[0]  = 8'hA5;
        step0(acc, at);
        chk("t6_accepted", int'(acc), 1);
        srdy[0] = 1'b0;
        din[0]  = 8'h00;
        idle0(4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_idle_vld", int'(vld[0]), 0);
            chk("t6_idle_data", int'(dout[0]), GATED ? 0 : 8'hA5);
        end

        for (int k = 0; k < 5000 && !b_done; k++) @(posedge clk);
        chk("b_finished", int'(b_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
